instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/if_pkg.sv | 18 +
 rtl/if_fifo.sv | 48 ++++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction fetch slice: FSM states, buffer entry
// layout and the fetch word size.
package if_pkg;
  localparam int IF_WORD_BYTES = 4;
  localparam int IF_XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [IF_XLEN-1:0] instr;
    logic [IF_XLEN-1:0] pcincr;
    logic               misalign;
  } if_entry_t;
endpackage

// File: rtl/if_fifo.sv
// Fetched-instruction buffer: circular storage with flush, head view and
// occupancy count. Flush dominates push and pop.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       RESET_N,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  if_entry_t                  din,
  output if_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  if_entry_t       slot_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            pop_ok;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!RESET_N || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (pop_ok) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr] <= din;
  end

  // Empty buffer presents zeros so decode never sees stale or unknown fields.
  assign head = (count != '0) ? slot_q[rd_ptr] : '0;
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request, results queued for decode.
// Optional misaligned-PC trap path enabled by IF_MISALIGN_TRAP_EN.
module instruction_fetch
  import if_pkg::*;
#(
  parameter int ARCHITECTURE = 32,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    RESET_N,
  input  logic [ARCHITECTURE-1:0] pc_i,
  input  logic                    redirect_i,
  output logic                    pc_take_o,
  output logic                    imem_req_o,
  output logic [ARCHITECTURE-1:0] imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [ARCHITECTURE-1:0] imem_rdata_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [ARCHITECTURE-1:0] id_instr_o,
  output logic [ARCHITECTURE-1:0] id_pcincr_o,
  output logic                    id_misalign_o
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ARCHITECTURE-1:0] WORD_C = ARCHITECTURE'(IF_WORD_BYTES);
`ifdef IF_MISALIGN_TRAP_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  if_state_e               state_q, state_d;
  logic [ARCHITECTURE-1:0] pc_q;
  logic [CW-1:0]           count;
  logic                    space, misalign, push, pop;
  if_entry_t               entry, head;

  assign space    = count < DEPTH_C;
  assign misalign = MISALIGN_EN && (pc_i[1:0] != 2'b00);
  assign pop      = id_valid_o && id_ready_i;

  always_ff @(posedge clk) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!RESET_N)       pc_q <= '0;
    else if (pc_take_o) pc_q <= pc_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!redirect_i && space && !misalign) state_d = REQ;
      REQ:     if (imem_ack_i) state_d = IDLE;
               else if (redirect_i) state_d = DROP;
      DROP:    if (imem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_take_o  = 1'b0;
    imem_req_o = 1'b0;
    push       = 1'b0;
    entry      = '{instr: imem_rdata_i, pcincr: pc_q + WORD_C, misalign: 1'b0};
    case (state_q)
      IDLE: begin
        pc_take_o = RESET_N && !redirect_i && space;
        // Misaligned PC bypasses memory and queues a trap marker instead.
        if (pc_take_o && misalign) begin
          push  = 1'b1;
          entry = '{instr: '0, pcincr: pc_i + WORD_C, misalign: 1'b1};
        end
      end
      REQ: begin
        imem_req_o = 1'b1;
        push       = imem_ack_i && !redirect_i;
      end
      DROP:    imem_req_o = 1'b1;
      default: ;
    endcase
  end

`ifdef IF_MISALIGN_TRAP_EN
  assign imem_addr_o = pc_q;
`else
  assign imem_addr_o = {pc_q[ARCHITECTURE-1:2], 2'b00};
`endif

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .RESET_N (RESET_N),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_i),
    .din     (entry),
    .head    (head),
    .count   (count)
  );

  assign id_valid_o    = count != '0;
  assign id_instr_o    = head.instr;
  assign id_pcincr_o   = head.pcincr;
  assign id_misalign_o = head.misalign && MISALIGN_EN;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, corner-case sequences
// and a randomized run against a transaction-level scoreboard.
module tb_instruction_fetch;
  localparam int DEPTH = 2;

  logic        clk, RESET_N, redirect_i, pc_take_o, imem_req_o, imem_ack_i;
  logic        id_valid_o, id_ready_i, id_misalign_o;
  logic [31:0] pc_i, imem_addr_o, imem_rdata_i, id_instr_o, id_pcincr_o;

  int unsigned n_cmp = 0, n_bad = 0;

  instruction_fetch #(.ARCHITECTURE(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .RESET_N(RESET_N), .pc_i(pc_i), .redirect_i(redirect_i),
    .pc_take_o(pc_take_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pcincr_o(id_pcincr_o), .id_misalign_o(id_misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; redirect_i = 1'b0; imem_ack_i = 1'b0; id_ready_i = 1'b0;
    adv(); adv();
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] pcincr;
    int          dly;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcincr;
  } ent_t;

  vec_t        vt[$];
  ent_t        exp_q[$];
  bit          outstanding, cancelled;
  logic [31:0] req_pc;
  int          takes;

  initial begin
    pc_i = 32'h0; imem_rdata_i = 32'h0;
    vt.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 0});
    vt.push_back('{32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 2});
    vt.push_back('{32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h8000_0000, 1});
    vt.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 0});
    vt.push_back('{32'h8000_0010, 32'h8000_0010, 32'h8000_0014, 3});
`ifndef IF_MISALIGN_TRAP_EN
    vt.push_back('{32'h0000_0102, 32'h0000_0100, 32'h0000_0106, 1});
`endif

    // Reset state
    do_reset();
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", id_valid_o, 0);
    chk("rst_misalign", id_misalign_o, 0);
    chk("rst_take", pc_take_o, 0);

    // Vector table: single fetch, variable ack latency
    foreach (vt[r]) begin
      RESET_N = 1'b1; pc_i = vt[r].pc; id_ready_i = 1'b0;
      #1 chk("vec_take", pc_take_o, 1);
      adv();
      pc_i = 32'hDEAD_0000;
      for (int k = 0; k <= vt[r].dly; k++) begin
        imem_ack_i = (k == vt[r].dly);
        imem_rdata_i = memf(vt[r].addr);
        #1;
        chk("vec_req", imem_req_o, 1);
        chk("vec_addr", imem_addr_o, vt[r].addr);
        adv();
      end
      imem_ack_i = 1'b0; RESET_N = 1'b0;
      #1;
      chk("vec_valid", id_valid_o, 1);
      chk("vec_instr", id_instr_o, memf(vt[r].addr));
      chk("vec_pcincr", id_pcincr_o, vt[r].pcincr);
      chk("vec_misalign", id_misalign_o, 0);
      chk("vec_take_in_rst", pc_take_o, 0);
      adv(); adv();
    end

    // Back-to-back throughput with immediate ack and ready decode
    do_reset();
    RESET_N = 1'b1; pc_i = 32'h0; id_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_ack_i = imem_req_o; imem_rdata_i = memf(imem_addr_o);
      #1;
      chk("thr_take", pc_take_o, (i % 2) == 0);
      if (id_valid_o) begin
        chk("thr_instr", id_instr_o, memf(32'h0));
        chk("thr_pcincr", id_pcincr_o, 32'h4);
      end
      adv();
    end

    // Decode stalled: buffer fills, fetching stops, resumes on ready
    do_reset();
    RESET_N = 1'b1; pc_i = 32'h40; takes = 0;
    for (int i = 0; i < 12; i++) begin
      imem_ack_i = imem_req_o; imem_rdata_i = memf(imem_addr_o);
      #1;
      if (pc_take_o) takes++;
      adv();
    end
    imem_ack_i = 1'b0;
    chk("stall_takes", 32'(takes), 32'd2);
    chk("stall_take", pc_take_o, 0);
    chk("stall_req", imem_req_o, 0);
    chk("stall_instr", id_instr_o, memf(32'h40));
    chk("stall_pcincr", id_pcincr_o, 32'h44);
    id_ready_i = 1'b1;
    adv();
    chk("stall_resume", pc_take_o, 1);

    // Redirect during REQ with a slow ack: data dropped, new PC fetched
    do_reset();
    RESET_N = 1'b1; pc_i = 32'h200; id_ready_i = 1'b1;
    #1 chk("drop_take0", pc_take_o, 1);
    adv();
    redirect_i = 1'b1; pc_i = 32'h300;
    #1 chk("drop_take_redir", pc_take_o, 0);
    adv();
    redirect_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      imem_ack_i = (k == 2); imem_rdata_i = memf(32'h200);
      #1;
      chk("drop_req", imem_req_o, 1);
      chk("drop_addr", imem_addr_o, 32'h200);
      chk("drop_take", pc_take_o, 0);
      adv();
    end
    imem_ack_i = 1'b0;
    chk("drop_valid", id_valid_o, 0);
    chk("drop_take_new", pc_take_o, 1);
    adv();
    chk("drop_new_addr", imem_addr_o, 32'h300);
    chk("drop_valid2", id_valid_o, 0);

    // Redirect coincident with ack and pop
    do_reset();
    RESET_N = 1'b1; pc_i = 32'h500;
    adv();
    imem_ack_i = 1'b1; imem_rdata_i = memf(32'h500);
    adv();
    imem_ack_i = 1'b0; pc_i = 32'h504;
    #1 chk("coin_take", pc_take_o, 1);
    adv();
    id_ready_i = 1'b1; imem_ack_i = 1'b1; redirect_i = 1'b1; imem_rdata_i = memf(32'h504);
    #1 chk("coin_valid_before", id_valid_o, 1);
    adv();
    id_ready_i = 1'b0; imem_ack_i = 1'b0; redirect_i = 1'b0;
    chk("coin_valid", id_valid_o, 0);
    adv();
    chk("coin_valid2", id_valid_o, 0);

    // Reset in the middle of a request, then a late ack while idle
    do_reset();
    RESET_N = 1'b1; pc_i = 32'h600;
    adv();
    RESET_N = 1'b0;
    #1 chk("mrst_take", pc_take_o, 0);
    adv();
    RESET_N = 1'b1; pc_i = 32'h700; imem_ack_i = 1'b1; imem_rdata_i = memf(32'h600);
    #1;
    chk("mrst_req_idle", imem_req_o, 0);
    chk("mrst_take_new", pc_take_o, 1);
    adv();
    imem_ack_i = 1'b0;
    chk("mrst_valid", id_valid_o, 0);
    chk("mrst_req", imem_req_o, 1);
    chk("mrst_addr", imem_addr_o, 32'h700);

`ifdef IF_MISALIGN_TRAP_EN
    do_reset();
    RESET_N = 1'b1; pc_i = 32'h102;
    #1;
    chk("mis_take", pc_take_o, 1);
    chk("mis_req0", imem_req_o, 0);
    adv();
    RESET_N = 1'b0;
    #1;
    chk("mis_req", imem_req_o, 0);
    chk("mis_valid", id_valid_o, 1);
    chk("mis_flag", id_misalign_o, 1);
    chk("mis_instr", id_instr_o, 32'h0);
    chk("mis_pcincr", id_pcincr_o, 32'h106);
`endif

    // Randomized traffic against a scoreboard of expected decode entries
    do_reset();
    RESET_N = 1'b1;
    exp_q.delete(); outstanding = 0; cancelled = 0; req_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      imem_ack_i = imem_req_o && ($urandom_range(0, 2) == 0);
      imem_rdata_i = memf(imem_addr_o);
      redirect_i = ($urandom_range(0, 11) == 0);
      id_ready_i = ($urandom_range(0, 3) != 0);
      pc_i = $urandom;
`ifdef IF_MISALIGN_TRAP_EN
      pc_i[1:0] = 2'b00;
`endif
      #1;
      chk("rnd_valid", id_valid_o, exp_q.size() != 0);
      if (outstanding) begin
        chk("rnd_req", imem_req_o, 1);
        chk("rnd_addr", imem_addr_o, req_pc & ~32'h3);
      end else begin
        chk("rnd_req_idle", imem_req_o, 0);
      end
      chk("rnd_take", pc_take_o, !outstanding && !redirect_i && (exp_q.size() < DEPTH));
      if (id_valid_o && exp_q.size() > 0) begin
        chk("rnd_instr", id_instr_o, exp_q[0].instr);
        chk("rnd_pcincr", id_pcincr_o, exp_q[0].pcincr);
        chk("rnd_misalign", id_misalign_o, 0);
      end
      if (redirect_i) begin
        exp_q.delete();
        if (outstanding) begin
          if (imem_ack_i) begin outstanding = 0; cancelled = 0; end
          else cancelled = 1;
        end
      end else begin
        if (id_valid_o && id_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (outstanding && imem_ack_i) begin
          if (!cancelled) exp_q.push_back('{memf(req_pc & ~32'h3), req_pc + 32'd4});
          outstanding = 0; cancelled = 0;
        end
      end
      if (pc_take_o) begin
        outstanding = 1; cancelled = 0; req_pc = pc_i;
      end
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
